// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: shared encodings for the multicycle RISC-V controller.
// Revision 1.0
`default_nettype none

package control_fsm_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_HALT     = 4'd11
   } state_t;

   localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OP_STORE  = 7'b0100011;
   localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] C_OP_JAL    = 7'b1101111;

   localparam logic [2:0] C_ALU_ADD = 3'b000;
   localparam logic [2:0] C_ALU_SUB = 3'b001;
   localparam logic [2:0] C_ALU_AND = 3'b010;
   localparam logic [2:0] C_ALU_OR  = 3'b011;
   localparam logic [2:0] C_ALU_SLT = 3'b101;

   localparam logic [1:0] C_SRCA_PC    = 2'b00;
   localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
   localparam logic [1:0] C_SRCA_RS1   = 2'b10;

   localparam logic [1:0] C_SRCB_RS2  = 2'b00;
   localparam logic [1:0] C_SRCB_IMM  = 2'b01;
   localparam logic [1:0] C_SRCB_FOUR = 2'b10;

   localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
   localparam logic [1:0] C_RES_MEMDATA   = 2'b01;
   localparam logic [1:0] C_RES_ALURESULT = 2'b10;

   localparam logic [1:0] C_IMM_I = 2'b00;
   localparam logic [1:0] C_IMM_S = 2'b01;
   localparam logic [1:0] C_IMM_B = 2'b10;
   localparam logic [1:0] C_IMM_J = 2'b11;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         C_OP_STORE:  imm_sel = C_IMM_S;
         C_OP_BRANCH: imm_sel = C_IMM_B;
         C_OP_JAL:    imm_sel = C_IMM_J;
         default:     imm_sel = C_IMM_I;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: funct3/funct7 to ALUControl mapping and branch-taken evaluation.
// Revision 1.0
`default_nettype none

module alu_decoder
   import control_fsm_pkg::*;
(
   input  logic       op5_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       z_i,
   input  logic       n_i,
   input  logic       v_i,
   input  logic       c_i,
   output logic [2:0] alu_control_o,
   output logic       taken_o
);

   always_comb begin
      alu_control_o = C_ALU_ADD;
      case (funct3_i)
         // funct7b5 only selects sub for register-register ops; addi keeps add
         3'b000:  alu_control_o = (op5_i & funct7b5_i) ? C_ALU_SUB : C_ALU_ADD;
         3'b010:  alu_control_o = C_ALU_SLT;
         3'b110:  alu_control_o = C_ALU_OR;
         3'b111:  alu_control_o = C_ALU_AND;
         default: alu_control_o = C_ALU_ADD;
      endcase
   end

   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         3'b000:  taken_o = z_i;
         3'b001:  taken_o = ~z_i;
         3'b100:  taken_o = n_i ^ v_i;
         3'b101:  taken_o = ~(n_i ^ v_i);
         3'b110:  taken_o = ~c_i;
         3'b111:  taken_o = c_i;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// control_fsm: multicycle RISC-V controller (fetch/decode/execute state machine).
// Revision 1.0
`default_nettype none

module control_fsm
   import control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   input  logic       C,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       illegal
);

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [2:0] w_func_alu;
   logic       w_taken;

   alu_decoder u_alu_decoder (
      .op5_i         (op[5]),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .z_i           (Z),
      .n_i           (N),
      .v_i           (V),
      .c_i           (C),
      .alu_control_o (w_func_alu),
      .taken_o       (w_taken)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = C_SRCA_PC;
      ALUSrcB    = C_SRCB_RS2;
      ResultSrc  = C_RES_ALUOUT;
      ALUControl = C_ALU_ADD;
      ImmSrc     = imm_sel(op);
      illegal    = illegal_q;

      case (state_q)
         ST_FETCH: begin
            ALUSrcB   = C_SRCB_FOUR;
            ResultSrc = C_RES_ALURESULT;
            PCWrite   = mem_ready;
            IRWrite   = mem_ready;
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            // speculative branch/jump target computed from OldPC + imm
            ALUSrcA = C_SRCA_OLDPC;
            ALUSrcB = C_SRCB_IMM;
            case (op)
               C_OP_LOAD, C_OP_STORE: state_d = ST_MEMADR;
               C_OP_RTYPE:            state_d = ST_EXECR;
               C_OP_ITYPE:            state_d = ST_EXECI;
               C_OP_BRANCH:           state_d = ST_BRANCH;
               C_OP_JAL:              state_d = ST_JAL;
               default: begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_MEMADR: begin
            ALUSrcA = C_SRCA_RS1;
            ALUSrcB = C_SRCB_IMM;
            state_d = op[5] ? ST_MEMWRITE : ST_MEMREAD;
         end
         ST_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            ResultSrc = C_RES_MEMDATA;
            RegWrite  = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_d = ST_FETCH;
         end
         ST_EXECR: begin
            ALUSrcA    = C_SRCA_RS1;
            ALUSrcB    = C_SRCB_RS2;
            ALUControl = w_func_alu;
            state_d    = ST_ALUWB;
         end
         ST_EXECI: begin
            ALUSrcA    = C_SRCA_RS1;
            ALUSrcB    = C_SRCB_IMM;
            ALUControl = w_func_alu;
            state_d    = ST_ALUWB;
         end
         ST_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_BRANCH: begin
            ALUSrcA    = C_SRCA_RS1;
            ALUSrcB    = C_SRCB_RS2;
            ALUControl = C_ALU_SUB;
            PCWrite    = w_taken;
            state_d    = ST_FETCH;
         end
         ST_JAL: begin
            ALUSrcA = C_SRCA_OLDPC;
            ALUSrcB = C_SRCB_FOUR;
            PCWrite = 1'b1;
            state_d = ST_ALUWB;
         end
         ST_HALT: begin
            illegal_d = 1'b1;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// tb_control_fsm: table-driven, scoreboard-checked bench for control_fsm.
// Revision 1.0
`default_nettype none

module tb_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Z, N, V, C, mem_ready;
   logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] ALUControl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Z(Z), .N(N), .V(V), .C(C), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
   );

   typedef struct {
      string      name;
      logic       rst_n;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [3:0] znvc;
      logic       mr;
      logic [16:0] exp;
   } vec_t;

   typedef struct {
      string       name;
      logic [16:0] exp;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,illegal}
   function automatic logic [16:0] pk(input logic pcw, irw, mw, rw, adr,
                                      input logic [1:0] a, b, res,
                                      input logic [2:0] alu,
                                      input logic [1:0] imm,
                                      input logic ill);
      return {pcw, irw, mw, rw, adr, a, b, res, alu, imm, ill};
   endfunction

   function automatic logic [16:0] dut_out();
      return {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
              ResultSrc, ALUControl, ImmSrc, illegal};
   endfunction

   task automatic add(input string nm, input logic r, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic [3:0] fl,
                      input logic mr, input logic [16:0] e);
      vec_t v;
      v.name = nm; v.rst_n = r; v.op = o; v.f3 = f3; v.f7 = f7;
      v.znvc = fl; v.mr = mr; v.exp = e;
      tbl.push_back(v);
   endtask

   // FETCH (mem ready) then DECODE for one instruction
   task automatic add_fd(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] fl, input logic [1:0] imm);
      add({nm, "_fetch"},  1, o, f3, f7, fl, 1, pk(1,1,0,0,0, 2'b00,2'b10,2'b10, 3'b000, imm, 0));
      add({nm, "_decode"}, 1, o, f3, f7, fl, 1, pk(0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000, imm, 0));
   endtask

   task automatic run_vec(input vec_t v);
      sb_t s;
      rst_n = v.rst_n; op = v.op; funct3 = v.f3; funct7b5 = v.f7;
      {Z, N, V, C} = v.znvc; mem_ready = v.mr;
      s.name = v.name; s.exp = v.exp;
      sb.push_back(s);
      @(negedge clk);
      s = sb.pop_front();
      n_checks++;
      if (dut_out() !== s.exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", s.name, dut_out(), s.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run1(input string nm, input logic r, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic [3:0] fl,
                       input logic mr, input logic [16:0] e);
      vec_t v;
      v.name = nm; v.rst_n = r; v.op = o; v.f3 = f3; v.f7 = f7;
      v.znvc = fl; v.mr = mr; v.exp = e;
      run_vec(v);
   endtask

   initial begin
      logic [16:0] e_f0, e_halt;
      e_f0   = pk(0,0,0,0,0, 2'b00,2'b10,2'b10, 3'b000, 2'b00, 0);
      e_halt = pk(0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 1);

      // reset hold and fetch stall
      add("rst_mr0_a", 0, 7'd0, 0, 0, 0, 0, e_f0);
      add("rst_mr0_b", 0, 7'd0, 0, 0, 0, 0, e_f0);
      add("fetch_stall_a", 1, 7'd0, 0, 0, 0, 0, e_f0);
      add("fetch_stall_b", 1, 7'd0, 0, 0, 0, 0, e_f0);
      // lw
      add_fd("lw", LW, 3'b010, 0, 0, 2'b00);
      add("lw_memadr",  1, LW, 3'b010, 0, 0, 0, pk(0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, 2'b00, 0));
      add("lw_memread", 1, LW, 3'b010, 0, 0, 1, pk(0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0));
      add("lw_memwb",   1, LW, 3'b010, 0, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b01, 3'b000, 2'b00, 0));
      // sw with two wait cycles
      add_fd("sw", SW, 3'b010, 0, 0, 2'b01);
      add("sw_memadr",  1, SW, 3'b010, 0, 0, 1, pk(0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, 2'b01, 0));
      add("sw_wait1",   1, SW, 3'b010, 0, 0, 0, pk(0,0,1,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0));
      add("sw_wait2",   1, SW, 3'b010, 0, 0, 0, pk(0,0,1,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0));
      add("sw_done",    1, SW, 3'b010, 0, 0, 1, pk(0,0,1,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0));
      // R-type sub
      add_fd("sub", RT, 3'b000, 1, 0, 2'b00);
      add("sub_execr", 1, RT, 3'b000, 1, 0, 1, pk(0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b00, 0));
      add("sub_aluwb", 1, RT, 3'b000, 1, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0));
      // addi with funct7b5 set stays add
      add_fd("addi", IT, 3'b000, 1, 0, 2'b00);
      add("addi_execi", 1, IT, 3'b000, 1, 0, 0, pk(0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, 2'b00, 0));
      add("addi_aluwb", 1, IT, 3'b000, 1, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0));
      // R-type and, I-type slt, I-type or
      add_fd("and", RT, 3'b111, 0, 0, 2'b00);
      add("and_execr", 1, RT, 3'b111, 0, 0, 0, pk(0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b010, 2'b00, 0));
      add("and_aluwb", 1, RT, 3'b111, 0, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0));
      add_fd("slti", IT, 3'b010, 0, 0, 2'b00);
      add("slti_execi", 1, IT, 3'b010, 0, 0, 0, pk(0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b101, 2'b00, 0));
      add("slti_aluwb", 1, IT, 3'b010, 0, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0));
      add_fd("ori", IT, 3'b110, 0, 0, 2'b00);
      add("ori_execi", 1, IT, 3'b110, 0, 0, 0, pk(0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b011, 2'b00, 0));
      add("ori_aluwb", 1, IT, 3'b110, 0, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0));
      // branch sweep: flags {Z,N,V,C}
      add_fd("beq_t", BR, 3'b000, 0, 4'b1000, 2'b10);
      add("beq_t_br",  1, BR, 3'b000, 0, 4'b1000, 1, pk(1,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b10, 0));
      add_fd("beq_n", BR, 3'b000, 0, 4'b0000, 2'b10);
      add("beq_n_br",  1, BR, 3'b000, 0, 4'b0000, 1, pk(0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b10, 0));
      add_fd("blt", BR, 3'b100, 0, 4'b0110, 2'b10);
      add("blt_br",    1, BR, 3'b100, 0, 4'b0110, 0, pk(0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b10, 0));
      add_fd("bltu", BR, 3'b110, 0, 4'b0000, 2'b10);
      add("bltu_br",   1, BR, 3'b110, 0, 4'b0000, 0, pk(1,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b10, 0));
      add_fd("bgeu", BR, 3'b111, 0, 4'b0000, 2'b10);
      add("bgeu_br",   1, BR, 3'b111, 0, 4'b0000, 0, pk(0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b10, 0));
      // jal
      add_fd("jal", JL, 3'b000, 0, 0, 2'b11);
      add("jal_jal",   1, JL, 3'b000, 0, 0, 0, pk(1,0,0,0,0, 2'b01,2'b10,2'b00, 3'b000, 2'b11, 0));
      add("jal_aluwb", 1, JL, 3'b000, 0, 0, 0, pk(0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b11, 0));

      rst_n = 0; op = 0; funct3 = 0; funct7b5 = 0;
      {Z, N, V, C} = 4'b0; mem_ready = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

      // reset while waiting in MEMWRITE abandons the store
      run1("rsw_fetch",  1, SW, 3'b010, 0, 0, 1, pk(1,1,0,0,0, 2'b00,2'b10,2'b10, 3'b000, 2'b01, 0));
      run1("rsw_decode", 1, SW, 3'b010, 0, 0, 0, pk(0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000, 2'b01, 0));
      run1("rsw_memadr", 1, SW, 3'b010, 0, 0, 0, pk(0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, 2'b01, 0));
      run1("rsw_wait",   0, SW, 3'b010, 0, 0, 0, pk(0,0,1,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0));
      run1("rsw_after",  1, 7'd0, 3'b000, 0, 0, 0, e_f0);

      // illegal opcode -> absorbing HALT, cleared only by reset
      run1("bad_fetch",  1, BAD, 3'b000, 0, 0, 1, pk(1,1,0,0,0, 2'b00,2'b10,2'b10, 3'b000, 2'b00, 0));
      run1("bad_decode", 1, BAD, 3'b000, 0, 0, 1, pk(0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000, 2'b00, 0));
      for (int k = 0; k < 10; k++)
         run1($sformatf("halt_%0d", k), 1, BAD, 3'b000, 0, 4'b1111, k[0], e_halt);
      run1("halt_rst",   0, 7'd0, 3'b000, 0, 0, 0, e_halt);
      run1("post_halt",  1, 7'd0, 3'b000, 0, 0, 0, e_f0);

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 op  in  7  instruction opcode, bits [6:0] of the instruction register.
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Z, N, V, C  in  1 each  ALU zero, negative, overflow and carry flags.
   - C is valid only for add/sub.
REQ-008 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-009 PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  write enables.
REQ-010 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-012 ALUSrcB  out  2  ALU operand B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-014 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-016 illegal  out  1  sticky flag: unsupported opcode seen.

Function
REQ-017 The block SHALL be a multicycle RISC-V controller with these states:
   - FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT.
REQ-018 Any output not listed for the current state SHALL be 0.
REQ-019 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
   - IRWrite = PCWrite = mem_ready.
   - Advance to DECODE only when mem_ready=1; otherwise hold.
REQ-020 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch/jump target), then transition on op:
   - 0000011 or 0100011 -> MEMADR
   - 0110011 -> EXECR
   - 0010011 -> EXECI
   - 1100011 -> BRANCH
   - 1101111 -> JAL
   - any other opcode -> HALT
REQ-021 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add.
   - Next state: MEMREAD if op[5]=0, else MEMWRITE.
REQ-022 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00.
   - Hold until mem_ready=1, then MEMWB.
REQ-023 MEMWB SHALL drive ResultSrc=01, RegWrite=1; next state FETCH.
REQ-024 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1.
   - MemWrite stays asserted while waiting; hold until mem_ready=1, then FETCH.
REQ-025 EXECR (ALUSrcB=00) and EXECI (ALUSrcB=01) SHALL drive ALUSrcA=10 with the function decode of REQ-029; next state ALUWB.
REQ-026 ALUWB SHALL drive ResultSrc=00, RegWrite=1; next state FETCH.
REQ-027 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, with PCWrite=taken; next state FETCH. taken by funct3:
   - 000: Z
   - 001: ~Z
   - 100: N^V
   - 101: ~(N^V)
   - 110: ~C
   - 111: C
   - other: 0
REQ-028 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-029 Function decode SHALL map funct3 to ALUControl:
   - 000: sub if op[5] & funct7b5, else add
   - 010: slt
   - 110: or
   - 111: and
   - any other: add
REQ-030 ImmSrc SHALL be combinational from op in every state:
   - 0100011 -> 01
   - 1100011 -> 10
   - 1101111 -> 11
   - otherwise 00
REQ-031 HALT SHALL be absorbing and set illegal=1, with all enables 0; only reset exits it.
REQ-032 mem_ready SHALL be ignored outside FETCH, MEMREAD and MEMWRITE.
REQ-033 State and illegal SHALL be registers; all other outputs SHALL be combinational from state, op, funct3, funct7b5, flags and mem_ready.

Reset
REQ-034 While rst_n=0 at a clk edge, the state SHALL become FETCH and illegal SHALL become 0.
REQ-035 Reset in any state, including mid-access, SHALL abandon the instruction with no further enable pulses from it.
REQ-036 Reset values of the combinational outputs SHALL be the FETCH values (REQ-019) with mem_ready as applied.

Structure
REQ-037 A shared package SHALL hold:
   - state encodings;
   - opcode constants;
   - ALUControl codes (000/001/010/011/101);
   - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc codes.
REQ-038 The function and branch decode SHALL live in one combinational sub-module, alu_decoder, instantiated once.

Verification
REQ-039 Reset with mem_ready=0 for 3 cycles -> FETCH held with PCWrite=0 and IRWrite=0; mem_ready=1 -> both pulse once, then DECODE.
REQ-040 lw (op 0000011) with mem_ready=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in MEMWB; 5 cycles total.
REQ-041 sw with mem_ready low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH; RegWrite never asserted.
REQ-042 R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; addi with funct7b5=1 (op[5]=0) -> ALUControl=000.
REQ-043 Branch sweep in BRANCH:
   - beq with Z=1 -> PCWrite=1; Z=0 -> 0.
   - blt with N=1, V=1 -> 0.
   - bltu with C=0 -> 1.
   - bgeu with C=0 -> 0.
REQ-044 op=1111111 -> HALT, illegal=1 from the next cycle; stays in HALT for 10 cycles; rst_n=0 -> FETCH and illegal=0.
